// File: rtl/coef_mac_accum.sv
// N-term signed dot product of sample and ROM coefficient streams.
// Three stages: multiply, accumulate, then round/shift/saturate to the output.
module coef_mac_accum #(
  parameter int N     = 8,
  parameter int DW    = 12,
  parameter int CW    = 10,
  parameter int AW    = 26,
  parameter int OW    = 16,
  parameter int SHIFT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          sof,
  input  logic [DW-1:0] din,
  input  logic [CW-1:0] coef,
  output logic [OW-1:0] dout,
  output logic          dout_valid,
  output logic          sat,
  output logic          abort,
  output logic          busy
);
  localparam int PW   = DW + CW;
  localparam int CNTW = $clog2(N);
  localparam logic signed [AW:0] RND  = (AW+1)'(1) << (SHIFT-1);
  localparam logic signed [AW:0] OMAX = (AW+1)'((64'sd1 <<< (OW-1)) - 64'sd1);
  localparam logic signed [AW:0] OMIN = -OMAX - (AW+1)'(1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic signed [PW-1:0]   prod_q, prod_d;
  logic                   p1_vld_q, p1_vld_d;
  logic                   p1_first_q, p1_first_d;
  logic                   p1_last_q, p1_last_d;
  logic                   abort_q, abort_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic                   done_q, done_d;
  logic [OW-1:0]          dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   sat_q, sat_d;
  logic signed [AW:0]     rnd, r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      prod_q       <= '0;
      p1_vld_q     <= 1'b0;
      p1_first_q   <= 1'b0;
      p1_last_q    <= 1'b0;
      abort_q      <= 1'b0;
      acc_q        <= '0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prod_q       <= prod_d;
      p1_vld_q     <= p1_vld_d;
      p1_first_q   <= p1_first_d;
      p1_last_q    <= p1_last_d;
      abort_q      <= abort_d;
      acc_q        <= acc_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sat_q        <= sat_d;
    end
  end

  // sof restarts the block even on what would have been its last term
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (enable) begin
      if (state_q == IDLE || sof) begin
        state_d = ACCUM;
        cnt_d   = CNTW'(1);
      end else if (cnt_q == CNTW'(N-1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_comb begin
    prod_d     = $signed(din) * $signed(coef);
    p1_vld_d   = enable;
    p1_first_d = (state_q == IDLE) || sof;
    p1_last_d  = (state_q == ACCUM) && !sof && (cnt_q == CNTW'(N-1));
    abort_d    = enable && sof && (state_q == ACCUM);

    acc_d  = acc_q;
    done_d = p1_vld_q && p1_last_q;
    if (p1_vld_q)
      acc_d = p1_first_q ? {{(AW-PW){prod_q[PW-1]}}, prod_q}
                         : acc_q + {{(AW-PW){prod_q[PW-1]}}, prod_q};

    // one extra bit so the rounding add cannot wrap
    rnd          = {acc_q[AW-1], acc_q} + RND;
    r            = rnd >>> SHIFT;
    dout_d       = dout_q;
    dout_valid_d = done_q;
    sat_d        = 1'b0;
    if (done_q) begin
      if (r > OMAX) begin
        dout_d = OMAX[OW-1:0];
        sat_d  = 1'b1;
      end else if (r < OMIN) begin
        dout_d = OMIN[OW-1:0];
        sat_d  = 1'b1;
      end else begin
        dout_d = r[OW-1:0];
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sat        = sat_q;
  assign abort      = abort_q;
  assign busy       = (state_q == ACCUM);
endmodule

// File: tb/tb_coef_mac_accum.sv
// Bench for coef_mac_accum: vector table of whole blocks plus hand-built
// bubble/abort/back-to-back/reset sequences, outputs checked via a queue.
module tb_coef_mac_accum;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               sof = 1'b0;
  logic signed [11:0] din = '0;
  logic signed [9:0]  coef = '0;
  logic [15:0]        dout;
  logic               dout_valid, sat, abort, busy;

  coef_mac_accum dut (
    .clk(clk), .rst(rst), .enable(enable), .sof(sof), .din(din), .coef(coef),
    .dout(dout), .dout_valid(dout_valid), .sat(sat), .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [11:0] d0;
    logic signed [11:0] dstep;
    logic signed [9:0]  c;
    logic [15:0]        exp_d;
    logic               exp_s;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        s;
    int          cyc;
  } exp_t;

  vec_t tbl[7];
  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   abort_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && dout_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cyc=%0d dout=%0d", cyc, $signed(dout));
      end else begin
        e = q.pop_front();
        if (dout !== e.d || sat !== e.s || cyc != e.cyc) begin
          errors++;
          $display("FAIL output got dout=%0d sat=%0b cyc=%0d want dout=%0d sat=%0b cyc=%0d",
                   $signed(dout), sat, cyc, $signed(e.d), e.s, e.cyc);
        end
      end
    end
    if (sat && !dout_valid) begin
      checks++;
      errors++;
      $display("FAIL sat_without_valid cyc=%0d", cyc);
    end
    if (abort) abort_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic s, input logic signed [11:0] d,
                        input logic signed [9:0] c);
    enable = en;
    sof    = s;
    din    = d;
    coef   = c;
  endtask

  task automatic drive(input logic en, input logic s, input logic signed [11:0] d,
                       input logic signed [9:0] c);
    @(negedge clk);
    set_in(en, s, d, c);
  endtask

  task automatic push(input logic [15:0] d, input logic s);
    exp_t e;
    e.d = d; e.s = s; e.cyc = cyc + 3;
    q.push_back(e);
  endtask

  task automatic blk(input logic signed [11:0] d0, input logic signed [11:0] step,
                     input logic signed [9:0] c, input logic first_sof,
                     input logic [15:0] exp_d, input logic exp_s);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) && first_sof, d0 + 12'(i) * step, c);
      if (i == 7) push(exp_d, exp_s);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    tbl[0] = '{12'sd1,     12'sd1, 10'sd256,  16'd36,     1'b0};
    tbl[1] = '{-12'sd1,    12'sd0, 10'sd80,   -16'sd2,    1'b0};
    tbl[2] = '{-12'sd2048, 12'sd0, -10'sd512, 16'h7fff,   1'b1};
    tbl[3] = '{12'sd16,    12'sd0, 10'sd1,    16'd1,      1'b0};
    tbl[4] = '{-12'sd16,   12'sd0, 10'sd1,    16'd0,      1'b0};
    tbl[5] = '{12'sd100,   12'sd0, -10'sd3,   -16'sd9,    1'b0};
    tbl[6] = '{-12'sd2048, 12'sd0, 10'sd511,  -16'sd32704, 1'b0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_sat", sat, 0);
    chk("rst_abort", abort, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      blk(tbl[v].d0, tbl[v].dstep, tbl[v].c, 1'b1, tbl[v].exp_d, tbl[v].exp_s);
      idle(4);
    end

    // bubbles: two idle cycles after terms 2 and 5
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, 12'sd3, 10'sd256);
      if (i == 7) push(16'd24, 1'b0);
      if (i == 1 || i == 4) begin
        for (int g = 0; g < 2; g++) begin
          drive(1'b0, 1'b1, 12'sd9, 10'sd9);
          chk("bubble_busy", busy, 1);
        end
      end
    end
    idle(5);
    chk("hold_dout", dout, 24);

    // abort: 5 terms, then sof restarts with 7 more terms
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 12'sd1, 10'sd256);
    drive(1'b1, 1'b1, 12'sd1, 10'sd256);
    @(negedge clk);
    chk("abort_pulse", abort, 1);
    chk("abort_busy", busy, 1);
    set_in(1'b1, 1'b0, 12'sd1, 10'sd256);
    for (int i = 2; i < 8; i++) begin
      drive(1'b1, 1'b0, 12'sd1, 10'sd256);
      if (i == 7) push(16'd8, 1'b0);
    end
    idle(5);

    // three back-to-back blocks, then reset part-way into a fourth
    for (int b = 0; b < 3; b++)
      blk(12'(b + 1), 12'sd0, 10'sd256, 1'b1, 16'(8 * (b + 1)), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 12'sd5, 10'sd256);
    @(negedge clk);
    chk("pre_rst_dout", dout, 24);
    set_in(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_abort", abort, 0);
    // first term without sof still starts a block from IDLE
    blk(12'sd1, 12'sd0, 10'sd256, 1'b0, 16'd8, 1'b0);
    idle(8);

    chk("queue_empty", q.size(), 0);
    chk("abort_count", abort_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/coef_mac_accum.md
Name: coef_mac_accum

Overview:
- Downstream consumer of the coefficient ROM address sequencer. Each cycle it takes one input sample and the matching signed coefficient word read from the transform ROM.
- Computes an N-term dot product, out = sum(x[n]*C[n]) over n = 0..N-1.
- Rounds, shifts and saturates the sum, then emits one transform coefficient per N accepted terms to the next quantisation/packing stage.

Parameters:
- N, 8, terms per output (power of two, 2..64).
- DW, 12, signed sample width.
- CW, 10, signed coefficient width.
- AW, 26, signed accumulator width (must be >= DW+CW+log2(N)).
- OW, 16, signed output width.
- SHIFT, 8, right shift applied to the sum (>= 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  din/coef valid this cycle (term accepted).
- sof  in  1  first term of a new block; qualified by enable.
- din  in  DW  signed sample, aligned with coef.
- coef  in  CW  signed ROM coefficient, already ROM-latency-aligned by the caller.
- dout  out  OW  rounded, saturated dot product.
- dout_valid  out  1  one-cycle strobe, dout valid.
- sat  out  1  one-cycle strobe with dout_valid when dout was clipped.
- abort  out  1  one-cycle strobe when a partial block is discarded.
- busy  out  1  high while a block is partially accumulated (state ACCUM).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are clk and rst.
- Reset (rst=1 at a clk edge): dout=0, dout_valid=0, sat=0, abort=0, busy=0, term counter=0, accumulator=0, pipeline valid bits=0, state=IDLE. Reset mid-block discards the partial sum silently (no abort).
- Pipeline, stage P1 (multiply): registers prod = din*coef (DW+CW bits, signed) plus the enable/first/last flags.
- Pipeline, stage P2 (accumulate): first term loads acc = sext(prod); later terms do acc = acc + sext(prod). AW bits, no wrap in legal parameter sets.
- Pipeline, stage P3 (output): r = (acc_final + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift. If r > 2^(OW-1)-1, dout = max and sat=1. If r < -2^(OW-1), dout = min and sat=1.
- Latency: dout_valid rises 3 clk edges after the edge that samples the Nth term, i.e. term at cycle t gives dout_valid in cycle t+3. Accepting a new block's first term on the cycle after the Nth term is allowed. Sustained throughput is 1 output per N cycles with no bubble.
- enable=0 inserts a bubble: counter, state and acc hold. The pipeline still drains terms already in flight.
- State IDLE to ACCUM: enable=1 (sof is ignored in IDLE; any accepted term starts a block). Term count becomes 1.
- State ACCUM to ACCUM: enable=1, sof=0, count < N-1. Count increments.
- State ACCUM to IDLE: enable=1 and count == N-1. Block is complete and the output is scheduled.
- Special case N... not applicable: N=1 is illegal, so no single-term block exists.
- sof=1 with enable=1 in ACCUM: the partial block is discarded and abort pulses (cycle t+1). The current term becomes term 0 of the new block (acc loaded, not added). Count = 1, state stays ACCUM. No dout_valid is produced for the discarded block.
- sof=1 with enable=0: ignored.
- dout holds its last value between strobes. sat and abort are zero except on their strobe cycles.
- busy = (state == ACCUM).

Test Plan:
- Basic sum: rst 2 cycles, then 8 consecutive terms with din=1..8, coef=256, sof on the first. Expect one dout_valid 3 cycles after the last term, dout=36, sat=0.
- Rounding, negative: 8 terms din=-1, coef=80 (sum -640). Expect dout=-2, since (-640+128)>>>8 = -2.
- Saturation: 8 terms din=-2048, coef=-512 (sum 8388608). Expect dout=32767, sat=1 on the same cycle as dout_valid.
- Bubbles: 8 terms din=3, coef=256, with enable low for 2 cycles after terms 2 and 5. Expect dout=24 exactly once, 3 cycles after the 8th accepted term; busy high throughout the gaps.
- Abort: 5 terms of a block, then sof+enable on the next term followed by 7 more terms (din=1, coef=256 for all). Expect abort pulse 1 cycle after the sof term, then a single dout=8. No output for the discarded 5 terms.
- Back-to-back and reset: 3 blocks of 8 with no gaps give outputs spaced exactly 8 cycles apart. rst asserted after 4 terms of a fourth block gives all outputs 0 next cycle, busy=0, no abort. The next block accumulates from zero.
